dest_demux: RTL and testbench

- Receive side of the arbiter datapath: takes the single muxed word stream produced by the arbiter-selected input FIFO pop.
- Decodes each word's destination field and pushes the word into one of four output FIFOs (P4..P7).
- Honors per-destination almost_full with a 2-entry in-order skid queue.
- Drives registered stall back to the arbiter so the arbiter stops popping while the queue is occupied.

---
 rtl/dest_demux.sv | 127 ++++++++++++
 tb/tb_dest_demux.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_demux.sv
// Destination demux: routes the arbiter's popped word stream into output FIFOs P4..P7
// through a 2-entry in-order skid queue. Define DEST_DEMUX_COUNT_EN for saturating push counters.
module dest_demux #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  almost_full_P4,
  input  logic                  almost_full_P5,
  input  logic                  almost_full_P6,
  input  logic                  almost_full_P7,
  output logic                  push_P4,
  output logic                  push_P5,
  output logic                  push_P6,
  output logic                  push_P7,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  stall,
  output logic                  err_overflow
`ifdef DEST_DEMUX_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  count_P4,
  output logic [CNT_WIDTH-1:0]  count_P5,
  output logic [CNT_WIDTH-1:0]  count_P6,
  output logic [CNT_WIDTH-1:0]  count_P7
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] q_head;
  logic [DATA_WIDTH-1:0] q_tail;
  logic [3:0]            push_vec;

  logic [DATA_WIDTH-1:0] cand;
  logic                  cand_valid;
  logic [1:0]            cand_dest;
  logic [3:0]            af_vec;
  logic                  emit;

  // The queue head always wins over a new arrival, so ordering is strictly preserved.
  always_comb begin
    cand       = (state != EMPTY) ? q_head : data_in;
    cand_valid = (state != EMPTY) || valid_in;
    cand_dest  = cand[DATA_WIDTH-1:DATA_WIDTH-2];
    af_vec     = {almost_full_P7, almost_full_P6, almost_full_P5, almost_full_P4};
    emit       = cand_valid && !af_vec[cand_dest];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= EMPTY;
      q_head       <= '0;
      q_tail       <= '0;
      push_vec     <= '0;
      data_out     <= '0;
      stall        <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      push_vec <= emit ? (4'b0001 << cand_dest) : 4'b0000;
      if (emit) data_out <= cand;

      case (state)
        EMPTY: begin
          if (valid_in && !emit) begin
            q_head <= data_in;
            state  <= ONE;
            stall  <= 1'b1;
          end else begin
            stall  <= 1'b0;
          end
        end
        ONE: begin
          stall <= 1'b1;
          if (emit && valid_in) begin
            q_head <= data_in;
          end else if (emit) begin
            state  <= EMPTY;
            stall  <= 1'b0;
          end else if (valid_in) begin
            q_tail <= data_in;
            state  <= TWO;
          end
        end
        TWO: begin
          stall <= 1'b1;
          if (emit) begin
            q_head <= q_tail;
            if (valid_in) q_tail <= data_in;
            else          state  <= ONE;
          end else if (valid_in) begin
            err_overflow <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign push_P4 = push_vec[0];
  assign push_P5 = push_vec[1];
  assign push_P6 = push_vec[2];
  assign push_P7 = push_vec[3];

`ifdef DEST_DEMUX_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt [4];

  // Counters follow the registered strobes and stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (push_vec[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_WIDTH'(1);
    end
  end

  assign count_P4 = cnt[0];
  assign count_P5 = cnt[1];
  assign count_P6 = cnt[2];
  assign count_P7 = cnt[3];
`endif

endmodule

// File: tb/tb_dest_demux.sv
// Bench for dest_demux: queue-based reference model checked every cycle, plus directed
// literal expectations for reset, bypass, blocking, overflow and counters.
module tb_dest_demux;

  localparam int DW = 6;
`ifdef DEST_DEMUX_COUNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [3:0]    af = 4'b0000;

  logic          push_P4, push_P5, push_P6, push_P7;
  logic [DW-1:0] data_out;
  logic          stall, err_overflow;
  logic [3:0]    push_vec;
`ifdef DEST_DEMUX_COUNT_EN
  logic [CW-1:0] count_P4, count_P5, count_P6, count_P7;
`endif

  int checks = 0;
  int errors = 0;

  dest_demux #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .almost_full_P4 (af[0]),
    .almost_full_P5 (af[1]),
    .almost_full_P6 (af[2]),
    .almost_full_P7 (af[3]),
    .push_P4        (push_P4),
    .push_P5        (push_P5),
    .push_P6        (push_P6),
    .push_P7        (push_P7),
    .data_out       (data_out),
    .stall          (stall),
    .err_overflow   (err_overflow)
`ifdef DEST_DEMUX_COUNT_EN
    ,
    .count_P4       (count_P4),
    .count_P5       (count_P5),
    .count_P6       (count_P6),
    .count_P7       (count_P7)
`endif
  );

  assign push_vec = {push_P7, push_P6, push_P5, push_P4};

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle: drive on the falling edge, return shortly after the rising edge.
  task automatic apply_stimulus(input logic v, input logic [DW-1:0] d, input logic [3:0] a);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    af       = a;
    @(posedge clk);
    #3;
  endtask

  // Reference model: the skid queue is just an ordered list of at most two words.
  logic [DW-1:0] mq[$];
  logic [3:0]    exp_push = '0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_stall = 1'b0;
  logic          exp_err = 1'b0;
  int            exp_cnt[4];
  bit            model_live = 1'b0;
  bit            m_from_q, m_have, m_taken;
  logic [DW-1:0] m_cand;
  logic [1:0]    m_dest;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      exp_push   = '0;
      exp_data   = '0;
      exp_stall  = 1'b0;
      exp_err    = 1'b0;
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      for (int i = 0; i < 4; i++)
        if (exp_push[i] && exp_cnt[i] < (1 << CW) - 1) exp_cnt[i]++;
      exp_push = '0;
      m_from_q = mq.size() > 0;
      m_have   = m_from_q || valid_in;
      m_cand   = m_from_q ? mq[0] : data_in;
      m_dest   = m_cand[DW-1 -: 2];
      m_taken  = 1'b0;
      if (m_have && !af[m_dest]) begin
        exp_push[m_dest] = 1'b1;
        exp_data = m_cand;
        if (m_from_q) void'(mq.pop_front());
        else          m_taken = 1'b1;
      end
      if (valid_in && !m_taken) begin
        if (mq.size() < 2) mq.push_back(data_in);
        else               exp_err = 1'b1;
      end
      exp_stall = mq.size() != 0;
    end
    if (model_live) begin
      #2;
      check_output("model_push", 32'(push_vec), 32'(exp_push));
      check_output("model_data", 32'(data_out), 32'(exp_data));
      check_output("model_stall", 32'(stall), 32'(exp_stall));
      check_output("model_err", 32'(err_overflow), 32'(exp_err));
`ifdef DEST_DEMUX_COUNT_EN
      check_output("model_cnt4", 32'(count_P4), 32'(exp_cnt[0]));
      check_output("model_cnt5", 32'(count_P5), 32'(exp_cnt[1]));
      check_output("model_cnt6", 32'(count_P6), 32'(exp_cnt[2]));
      check_output("model_cnt7", 32'(count_P7), 32'(exp_cnt[3]));
`endif
    end
  end

  initial begin
    #2;
    reset    = 1'b0;
    valid_in = 1'b1;
    data_in  = 6'h3F;
    #1;
    check_output("rst_push", 32'(push_vec), 32'h0);
    check_output("rst_data", 32'(data_out), 32'h0);
    check_output("rst_stall", 32'(stall), 32'h0);
    check_output("rst_err", 32'(err_overflow), 32'h0);
    apply_stimulus(1'b1, 6'h3F, 4'b0000);
    apply_stimulus(1'b1, 6'h3F, 4'b0000);
    check_output("rst_hold_push", 32'(push_vec), 32'h0);

    reset = 1'b1;
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("release_push", 32'(push_vec), 32'h0);
    check_output("release_stall", 32'(stall), 32'h0);

    // Bypass
    apply_stimulus(1'b1, 6'h25, 4'b0000);
    check_output("bypass_push", 32'(push_vec), 32'b0100);
    check_output("bypass_data", 32'(data_out), 32'h25);
    check_output("bypass_stall", 32'(stall), 32'h0);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("bypass_idle", 32'(push_vec), 32'h0);

    // Block then drain in order
    apply_stimulus(1'b1, 6'h1A, 4'b0010);
    check_output("blk_push", 32'(push_vec), 32'h0);
    check_output("blk_stall", 32'(stall), 32'h1);
    apply_stimulus(1'b1, 6'h05, 4'b0010);
    check_output("blk2_push", 32'(push_vec), 32'h0);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("drain1_push", 32'(push_vec), 32'b0010);
    check_output("drain1_data", 32'(data_out), 32'h1A);
    check_output("drain1_stall", 32'(stall), 32'h1);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("drain2_push", 32'(push_vec), 32'b0001);
    check_output("drain2_data", 32'(data_out), 32'h05);
    check_output("drain2_stall", 32'(stall), 32'h0);

    // Emit + arrival while holding one word
    apply_stimulus(1'b1, 6'h1B, 4'b0010);
    apply_stimulus(1'b1, 6'h2A, 4'b0000);
    check_output("one_push", 32'(push_vec), 32'b0010);
    check_output("one_data", 32'(data_out), 32'h1B);
    check_output("one_stall", 32'(stall), 32'h1);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("one_next", 32'(data_out), 32'h2A);
    check_output("one_empty", 32'(stall), 32'h0);

    // Emit + arrival while holding two words
    apply_stimulus(1'b1, 6'h1C, 4'b0010);
    apply_stimulus(1'b1, 6'h1D, 4'b0010);
    apply_stimulus(1'b1, 6'h0E, 4'b0000);
    check_output("two_data", 32'(data_out), 32'h1C);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("two_data2", 32'(data_out), 32'h1D);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("two_push3", 32'(push_vec), 32'b0001);
    check_output("two_data3", 32'(data_out), 32'h0E);

    // Overflow
    apply_stimulus(1'b1, 6'h30, 4'b1000);
    apply_stimulus(1'b1, 6'h31, 4'b1000);
    check_output("ovf_pre_err", 32'(err_overflow), 32'h0);
    apply_stimulus(1'b1, 6'h32, 4'b1000);
    check_output("ovf_err", 32'(err_overflow), 32'h1);
    check_output("ovf_push", 32'(push_vec), 32'h0);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("ovf_d1", 32'(data_out), 32'h30);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("ovf_d2", 32'(data_out), 32'h31);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("ovf_push_none", 32'(push_vec), 32'h0);
    check_output("ovf_sticky", 32'(err_overflow), 32'h1);

    // Reset while words are queued
    apply_stimulus(1'b1, 6'h05, 4'b0001);
    apply_stimulus(1'b1, 6'h06, 4'b0001);
    reset = 1'b0;
    #1;
    check_output("midrst_stall", 32'(stall), 32'h0);
    check_output("midrst_err", 32'(err_overflow), 32'h0);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    reset = 1'b1;
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("midrst_nopush", 32'(push_vec), 32'h0);

`ifdef DEST_DEMUX_COUNT_EN
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 6'h25, 4'b0000);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("cnt6_three", 32'(count_P6), 32'd3);
    check_output("cnt4_zero", 32'(count_P4), 32'd0);
    check_output("cnt5_zero", 32'(count_P5), 32'd0);
    check_output("cnt7_zero", 32'(count_P7), 32'd0);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 6'h25, 4'b0000);
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    check_output("cnt6_sat", 32'(count_P6), 32'd3);
`endif

    // Mixed traffic, checked by the model alone
    for (int i = 0; i < 300; i++)
      apply_stimulus(1'($urandom_range(0, 1)), DW'($urandom), 4'($urandom_range(0, 15)));
    apply_stimulus(1'b0, 6'h00, 4'b0000);
    apply_stimulus(1'b0, 6'h00, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
